// File: rtl/flu_cmd_sequencer_pkg.sv
// ============================================================================
// flu_pkg : shared types and constants for the FLU command sequencer
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package flu_pkg;

  localparam int CTL_W       = 4;
  localparam int FRAME_BYTES = 9;

  localparam logic [CTL_W-1:0] CTL_ADD  = 4'd1;
  localparam logic [CTL_W-1:0] CTL_SUB  = 4'd2;
  localparam logic [CTL_W-1:0] CTL_AND  = 4'd3;
  localparam logic [CTL_W-1:0] CTL_OR   = 4'd4;
  localparam logic [CTL_W-1:0] CTL_XOR  = 4'd5;
  localparam logic [CTL_W-1:0] CTL_SHL  = 4'd6;
  localparam logic [CTL_W-1:0] CTL_SHR  = 4'd7;
  localparam logic [CTL_W-1:0] CTL_SRA  = 4'd8;
  localparam logic [CTL_W-1:0] CTL_SLTU = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/flu_cmd_sequencer_flu.sv
// ============================================================================
// flu_cmd_sequencer_flu : purely combinational function/logic unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module flu_cmd_sequencer_flu
  import flu_pkg::*;
(
  input  logic [31:0]      i_a,
  input  logic [31:0]      i_b,
  input  logic [CTL_W-1:0] i_ctl,
  output logic [31:0]      o_out
);

  always_comb begin
    o_out = 32'h0;
    case (i_ctl)
      CTL_ADD:  o_out = i_a + i_b;
      CTL_SUB:  o_out = i_a - i_b;
      CTL_AND:  o_out = i_a & i_b;
      CTL_OR:   o_out = i_a | i_b;
      CTL_XOR:  o_out = i_a ^ i_b;
      CTL_SHL:  o_out = i_a << i_b[4:0];
      CTL_SHR:  o_out = i_a >> i_b[4:0];
      CTL_SRA:  o_out = $signed(i_a) >>> i_b[4:0];
      CTL_SLTU: o_out = {31'h0, (i_a < i_b)};
      default:  o_out = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/flu_cmd_sequencer.sv
// ============================================================================
// flu_cmd_sequencer : byte-serial frame assembler, FLU driver and result port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module flu_cmd_sequencer
  import flu_pkg::*;
#(
  parameter int MAX_CTL = 9,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [CTL_W-1:0] res_ctl,
  output logic             res_err,
  output logic             frame_abort,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int              OPER_BYTES = (FRAME_BYTES - 1) / 2;
  localparam logic [1:0]      IDX_LAST   = 2'(OPER_BYTES - 1);
  localparam int              TO_W       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [CTL_W-1:0]  r_ctl;
  logic              r_err;
  logic [1:0]        r_idx;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_in_ready;
  logic              r_res_valid;
  logic [31:0]       r_res_data;
  logic [CTL_W-1:0]  r_res_ctl;
  logic              r_res_err;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [31:0]       w_flu_out;
  logic              w_accept;
  logic              w_loading;
  logic              w_timeout;
  logic              w_res_take;
  logic              w_byte_err;

  assign w_accept   = in_valid & r_in_ready;
  assign w_loading  = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
  // An accepted byte beats a timeout landing in the same cycle.
  assign w_timeout  = (TIMEOUT != 0) && w_loading && !w_accept && (r_to_cnt == TO_LIMIT);
  assign w_res_take = r_res_valid & res_ready;
  assign w_byte_err = (in_data[7:4] != 4'h0) || (in_data[3:0] == 4'h0) ||
                      (int'(in_data[3:0]) > MAX_CTL);

  flu_cmd_sequencer_flu u_flu (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_ctl (r_ctl),
    .o_out (w_flu_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_LOAD_A;
      ST_LOAD_A: begin
        if (w_timeout)                          w_next = ST_IDLE;
        else if (w_accept && r_idx == IDX_LAST) w_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        if (w_timeout)                          w_next = ST_IDLE;
        else if (w_accept && r_idx == IDX_LAST) w_next = ST_EXEC;
      end
      ST_EXEC:   w_next = ST_HOLD;
      ST_HOLD:   if (w_res_take) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_ctl       <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_to_cnt    <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ctl   <= '0;
      r_res_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      // Registered ready, derived from where the FSM is heading.
      r_in_ready <= (w_next == ST_IDLE) || (w_next == ST_LOAD_A) || (w_next == ST_LOAD_B);

      if (w_accept || w_timeout || !w_loading || TIMEOUT == 0) r_to_cnt <= '0;
      else                                                      r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_timeout) begin
        r_a   <= '0;
        r_b   <= '0;
        r_idx <= '0;
      end else if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            r_ctl <= in_data[3:0];
            r_err <= w_byte_err;
            r_idx <= '0;
          end
          ST_LOAD_A: begin
            r_a   <= {r_a[23:0], in_data};
            r_idx <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
          end
          ST_LOAD_B: begin
            r_b   <= {r_b[23:0], in_data};
            r_idx <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
          end
          default: ;
        endcase
      end

      if (r_state == ST_EXEC) begin
        r_res_data  <= r_err ? 32'h0 : w_flu_out;
        r_res_ctl   <= r_ctl;
        r_res_err   <= r_err;
        r_res_valid <= 1'b1;
      end else if (w_res_take) begin
        r_res_valid <= 1'b0;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready    = r_in_ready;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_ctl     = r_res_ctl;
  assign res_err     = r_res_err;
  assign frame_abort = w_timeout;
  assign busy        = (r_state != ST_IDLE);
  assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_flu_cmd_sequencer.sv
// ============================================================================
// tb_flu_cmd_sequencer : directed and randomized bench with a frame scoreboard
// Rev 1.0 : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_flu_cmd_sequencer;

  localparam int TB_MAX_CTL = 9;
  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int WAIT_LIMIT = 200;

  typedef struct packed {
    logic        err;
    logic [3:0]  ctl;
    logic [31:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic res_ready = 1'b0;
  logic in_ready, res_valid, res_err, frame_abort, busy;
  logic [31:0] res_data;
  logic [3:0] res_ctl;
  logic [TB_CNT_W-1:0] frame_cnt;

  flu_cmd_sequencer #(
    .MAX_CTL (TB_MAX_CTL),
    .TIMEOUT (TB_TIMEOUT),
    .CNT_W   (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_ctl     (res_ctl),
    .res_err     (res_err),
    .frame_abort (frame_abort),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   exp_cnt = 0;
  int   aborts_seen = 0;
  int   aborts_exp = 0;
  int   rr_mode = 0;   // 0: always ready, 1: random, 2: held low
  time  b0_time = 0;
  res_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference FLU: plain arithmetic on the operand values.
  function automatic logic [31:0] flu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (c)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return a << sh;
      4'd7: return a >> sh;
      4'd8: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_expected(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    r.ctl  = b0[3:0];
    r.err  = (b0[7:4] != 4'h0) || (b0[3:0] == 4'h0) || (int'(b0[3:0]) > TB_MAX_CTL);
    r.data = r.err ? 32'h0 : flu_model(b0[3:0], a, b);
    exp_q.push_back(r);
  endtask

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = ($urandom_range(0, 2) != 0);
      default: res_ready = 1'b0;
    endcase
  end

  // Every-cycle scoreboard on the result port and frame counter.
  always @(negedge clk) begin
    if (!rst) begin
      check("frame_cnt", 64'(frame_cnt), 64'(exp_cnt % (1 << TB_CNT_W)));
      if (frame_abort) aborts_seen++;
      if (res_valid) begin
        check("in_ready_while_valid", 64'(in_ready), 64'd0);
        check("busy_while_valid", 64'(busy), 64'd1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got res_valid=1 want no pending frame");
        end else begin
          check("res_data", 64'(res_data), 64'(exp_q[0].data));
          check("res_ctl", 64'(res_ctl), 64'(exp_q[0].ctl));
          check("res_err", 64'(res_err), 64'(exp_q[0].err));
          if (res_ready) begin
            void'(exp_q.pop_front());
            exp_cnt++;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL byte_accept: got in_ready=0 want 1 within %0d cycles", WAIT_LIMIT);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] b,
                            input int gmin, input int gmax, input int nbytes);
    logic [7:0] fb [9];
    fb[0] = b0;
    for (int i = 0; i < 4; i++) begin
      fb[1+i] = a[31-8*i -: 8];
      fb[5+i] = b[31-8*i -: 8];
    end
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0) idle(int'($urandom_range(gmin, gmax)));
      if (i == 8) push_expected(b0, a, b);
      send_byte(fb[i]);
      if (i == 0) b0_time = $time;
    end
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      total++;
      bad++;
      $display("FAIL wait_result: got res_valid=0 want 1 within %0d cycles", WAIT_LIMIT);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk);
    while (exp_q.size() != 0 && n < WAIT_LIMIT) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending results want 0", exp_q.size());
    end
  endtask

  task automatic pin_frame(input logic [7:0] b0, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lit_data, input logic [3:0] lit_ctl, input logic lit_err);
    send_frame(b0, a, b, 0, 0, 9);
    wait_res();
    check($sformatf("pin_data_%02h", b0), 64'(res_data), 64'(lit_data));
    check($sformatf("pin_ctl_%02h", b0), 64'(res_ctl), 64'(lit_ctl));
    check($sformatf("pin_err_%02h", b0), 64'(res_err), 64'(lit_err));
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_data"}, 64'(res_data), 64'd0);
    check({tag, "_res_ctl"}, 64'(res_ctl), 64'd0);
    check({tag, "_res_err"}, 64'(res_err), 64'd0);
    check({tag, "_frame_abort"}, 64'(frame_abort), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rb0;
    logic [31:0] ra, rbb;
    time         prev_b0;

    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_before_first_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("in_ready_after_first_edge", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;

    // Reference frame: latency and literal result.
    send_frame(8'h01, 32'h4123_3333, 32'h40A3_3333, 0, 0, 9);
    @(negedge clk);
    check("exec_res_valid", 64'(res_valid), 64'd0);
    check("exec_busy", 64'(busy), 64'd1);
    check("exec_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("hold_res_valid", 64'(res_valid), 64'd1);
    check("hold_res_data", 64'(res_data), 64'h81C6_6666);
    check("hold_res_ctl", 64'(res_ctl), 64'd1);
    check("hold_res_err", 64'(res_err), 64'd0);
    @(negedge clk);
    check("done_res_valid", 64'(res_valid), 64'd0);
    check("done_frame_cnt", 64'(frame_cnt), 64'd1);
    check("done_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #2;

    // Back-to-back ctl 1..9; each frame start 11 cycles after the previous one.
    prev_b0 = 0;
    for (int c = 1; c <= 9; c++) begin
      send_frame({4'h0, 4'(c)}, 32'h4123_3333, 32'h4123_3333, 0, 0, 9);
      if (c > 1) check($sformatf("frame_period_%0d", c), 64'((b0_time - prev_b0) / 10), 64'd11);
      prev_b0 = b0_time;
    end
    wait_idle();
    check("cnt_after_seq", 64'(frame_cnt), 64'd10);

    pin_frame(8'h02, 32'h4123_3333, 32'h40A3_3333, 32'h0080_0000, 4'd2, 1'b0);
    pin_frame(8'h05, 32'h4123_3333, 32'h40A3_3333, 32'h0180_0000, 4'd5, 1'b0);
    pin_frame(8'h08, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 4'd8, 1'b0);
    pin_frame(8'h06, 32'h0000_0001, 32'h0000_0025, 32'h0000_0020, 4'd6, 1'b0);
    pin_frame(8'h09, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 4'd9, 1'b0);
    // Error frames: out-of-range ctl, zero ctl, nonzero upper nibble, MAX_CTL+1.
    pin_frame(8'h0F, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'hF, 1'b1);
    pin_frame(8'h00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'h0, 1'b1);
    pin_frame(8'h19, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'h9, 1'b1);
    pin_frame(8'h0A, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'hA, 1'b1);

    // Stall in HOLD while the next frame's first byte waits upstream.
    rr_mode = 2;
    send_frame(8'h04, 32'h0F0F_0000, 32'h00F0_F00F, 0, 0, 9);
    fork
      send_frame(8'h01, 32'h0000_0010, 32'h0000_0020, 0, 1, 9);
      begin
        wait_res();
        repeat (20) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          @(negedge clk);
        end
        rr_mode = 0;
        @(negedge clk);
        check("stall_last_valid", 64'(res_valid), 64'd1);
        check("stall_last_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_after_take", 64'(in_ready), 64'd1);
      end
    join
    wait_idle();

    // Timeout after the third byte.
    send_frame(8'h01, 32'hAABB_CCDD, 32'h1122_3344, 0, 0, 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("abort_k%0d", k), 64'(frame_abort), 64'(k == 5));
      check($sformatf("busy_k%0d", k), 64'(busy), 64'(k < 6));
    end
    @(posedge clk);
    #2;
    aborts_exp++;
    check("abort_count", 64'(aborts_seen), 64'(aborts_exp));
    pin_frame(8'h03, 32'h4123_3333, 32'h40A3_3333, 32'h4023_3333, 4'd3, 1'b0);
    // Gaps of exactly TIMEOUT: each byte lands as the counter hits the limit.
    send_frame(8'h07, 32'hF000_000F, 32'h0000_0003, TB_TIMEOUT, TB_TIMEOUT, 9);
    wait_idle();
    check("no_abort_at_limit", 64'(aborts_seen), 64'(aborts_exp));

    // Reset in LOAD_B.
    send_frame(8'h01, 32'h1111_1111, 32'h2222_2222, 0, 0, 7);
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_all_zero("rst_loadb");
    idle(2);
    rst = 1'b0;
    pin_frame(8'h01, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 4'd1, 1'b0);

    // Reset in HOLD.
    rr_mode = 2;
    send_frame(8'h05, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 9);
    wait_res();
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_all_zero("rst_hold");
    rr_mode = 0;
    idle(2);
    rst = 1'b0;
    pin_frame(8'h04, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hFFFF_0F0F, 4'd4, 1'b0);

    // Randomized frames with random backpressure, gaps and aborts; frame_cnt wraps.
    rr_mode = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 7) rb0 = {4'h0, 4'($urandom_range(1, 9))};
      else                          rb0 = 8'($urandom);
      ra  = $urandom;
      rbb = $urandom;
      idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 6) == 0) begin
        send_frame(rb0, ra, rbb, 0, TB_TIMEOUT, int'($urandom_range(1, 8)));
        idle(TB_TIMEOUT + 1 + int'($urandom_range(0, 3)));
        aborts_exp++;
      end else begin
        send_frame(rb0, ra, rbb, 0, TB_TIMEOUT, 9);
      end
    end
    wait_idle();
    check("final_abort_count", 64'(aborts_seen), 64'(aborts_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
